// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised MIPS register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int unsigned MAX_DATA_W = 64;
  localparam logic [MAX_DATA_W-1:0] RESET_VALUE = '0;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_param_if.sv
// Bus between decode / write-back / ALU operand muxes and the register file.
interface regfile_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  import regfile_pkg::*;

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic              Reg_Write_i;
  logic [ADDR_W-1:0] Write_Register_i;
  logic [DATA_W-1:0] Write_Data_i;
  logic [ADDR_W-1:0] Read_Register_1_i;
  logic [ADDR_W-1:0] Read_Register_2_i;
  logic              Clear_Req_i;
  logic [DATA_W-1:0] Read_Data_1_o;
  logic [DATA_W-1:0] Read_Data_2_o;
  logic              Busy_o;
  logic              Clear_Done_o;
  logic [DEPTH-1:0]  Wr_Onehot_o;

  modport master (
    output Reg_Write_i, Write_Register_i, Write_Data_i,
    output Read_Register_1_i, Read_Register_2_i, Clear_Req_i,
    input  Read_Data_1_o, Read_Data_2_o, Busy_o, Clear_Done_o, Wr_Onehot_o
  );

  modport slave (
    input  Reg_Write_i, Write_Register_i, Write_Data_i,
    input  Read_Register_1_i, Read_Register_2_i, Clear_Req_i,
    output Read_Data_1_o, Read_Data_2_o, Busy_o, Clear_Done_o, Wr_Onehot_o
  );

endinterface

// File: rtl/regfile_param_wr_decoder.sv
// Enabled one-hot write decoder; entry 0 is never written.
module wr_decoder
  import regfile_pkg::*;
#(
  parameter  int unsigned ADDR_W = 5,
  localparam int unsigned DEPTH  = depth_of(ADDR_W)
) (
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DEPTH-1:0]  o_onehot
);

  always_comb begin
    // NOTE: default every output first so no path leaves it unassigned (no latch).
    o_onehot = '0;
    if (i_en) o_onehot[i_addr] = 1'b1;
    o_onehot[0] = 1'b0;
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: hardwired r0, optional bypass / registered read,
// and a sequential bulk-clear sweep with busy/done handshake.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          REG_OUT = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  regfile_param_if.slave  bus
);

  localparam int unsigned       DEPTH    = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_e            r_state, w_next_state;
  logic [ADDR_W-1:0] r_ptr, w_next_ptr;
  logic              w_busy;
  logic              w_done;
  logic [DEPTH-1:0]  w_wr_onehot;
  logic [DATA_W-1:0] w_mem [DEPTH];
  logic [DATA_W-1:0] w_rd1, w_rd2;

  assign w_busy = (r_state == CLEAR);
  assign w_done = w_busy && (r_ptr == LAST_PTR);

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_next_state;
      r_ptr   <= w_next_ptr;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_ptr;
    unique case (r_state)
      IDLE: begin
        if (bus.Clear_Req_i) begin
          w_next_state = CLEAR;
          w_next_ptr   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        if (r_ptr == LAST_PTR) begin
          w_next_state = IDLE;
          w_next_ptr   = '0;
        end else begin
          w_next_ptr   = r_ptr + ADDR_W'(1);
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_ptr   = '0;
      end
    endcase
  end

  wr_decoder #(.ADDR_W(ADDR_W)) u_wr_decoder (
    .i_en     (bus.Reg_Write_i & ~w_busy),
    .i_addr   (bus.Write_Register_i),
    .o_onehot (w_wr_onehot)
  );

  assign w_mem[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    logic [DATA_W-1:0] r_q;
    // NOTE: the file is flops, not SRAM, so every entry takes the async reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                 r_q <= RESET_VALUE[DATA_W-1:0];
      else if (w_busy && r_ptr == ADDR_W'(i))     r_q <= '0;
      else if (w_wr_onehot[i])                    r_q <= bus.Write_Data_i;
    end
    assign w_mem[i] = r_q;
  end

  // A set onehot bit already implies enable, not busy, nonzero and address match.
  always_comb begin
    w_rd1 = w_mem[bus.Read_Register_1_i];
    w_rd2 = w_mem[bus.Read_Register_2_i];
    if (BYPASS && w_wr_onehot[bus.Read_Register_1_i]) w_rd1 = bus.Write_Data_i;
    if (BYPASS && w_wr_onehot[bus.Read_Register_2_i]) w_rd2 = bus.Write_Data_i;
  end

  if (REG_OUT) begin : g_reg_out
    logic [DATA_W-1:0] r_rd1, r_rd2;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_rd1 <= '0;
        r_rd2 <= '0;
      end else begin
        r_rd1 <= w_rd1;
        r_rd2 <= w_rd2;
      end
    end
    assign bus.Read_Data_1_o = r_rd1;
    assign bus.Read_Data_2_o = r_rd2;
  end else begin : g_comb_out
    assign bus.Read_Data_1_o = w_rd1;
    assign bus.Read_Data_2_o = w_rd2;
  end

  assign bus.Busy_o       = w_busy;
  assign bus.Clear_Done_o = w_done;
  assign bus.Wr_Onehot_o  = w_wr_onehot;

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench: three configurations share stimulus; a monitor checks each cycle.
module tb_regfile_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef struct {
    logic [31:0] a1, a2, b1, b2, c1, c2;
    logic        busy, done;
    logic [31:0] oh;
  } exp_t;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] mem [DEPTH];
  int          sweep;
  logic [31:0] c1_hold, c2_hold;

  regfile_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifa ();
  regfile_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifb ();
  regfile_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifc ();

  regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b1), .REG_OUT(1'b0))
    u_a (.clk(clk), .reset(reset), .bus(ifa));
  regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0), .REG_OUT(1'b0))
    u_b (.clk(clk), .reset(reset), .bus(ifb));
  regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b1), .REG_OUT(1'b1))
    u_c (.clk(clk), .reset(reset), .bus(ifc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit we, input int wa, input logic [31:0] wd,
                       input int ra1, input int ra2, input bit req);
    ifa.Reg_Write_i = we; ifa.Write_Register_i = ADDR_W'(wa); ifa.Write_Data_i = wd;
    ifa.Read_Register_1_i = ADDR_W'(ra1); ifa.Read_Register_2_i = ADDR_W'(ra2); ifa.Clear_Req_i = req;
    ifb.Reg_Write_i = we; ifb.Write_Register_i = ADDR_W'(wa); ifb.Write_Data_i = wd;
    ifb.Read_Register_1_i = ADDR_W'(ra1); ifb.Read_Register_2_i = ADDR_W'(ra2); ifb.Clear_Req_i = req;
    ifc.Reg_Write_i = we; ifc.Write_Register_i = ADDR_W'(wa); ifc.Write_Data_i = wd;
    ifc.Read_Register_1_i = ADDR_W'(ra1); ifc.Read_Register_2_i = ADDR_W'(ra2); ifc.Clear_Req_i = req;
  endtask

  function automatic logic [31:0] model_read(input int ra, input bit byp, input bit eff,
                                             input int wa, input logic [31:0] wd);
    if (ra == 0) return 32'h0;
    if (byp && eff && wa == ra) return wd;
    return mem[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    sweep   = 0;
    c1_hold = 32'h0;
    c2_hold = 32'h0;
  endtask

  // One clock cycle of stimulus; expectations reflect the model before the closing edge.
  task automatic cycle(input bit we, input int wa, input logic [31:0] wd,
                       input int ra1, input int ra2, input bit req);
    exp_t e;
    bit   busy, eff;
    @(posedge clk);
    #1;
    drive(we, wa, wd, ra1, ra2, req);
    busy   = (sweep != 0);
    eff    = we && !busy;
    e.a1   = model_read(ra1, 1'b1, eff, wa, wd);
    e.a2   = model_read(ra2, 1'b1, eff, wa, wd);
    e.b1   = model_read(ra1, 1'b0, eff, wa, wd);
    e.b2   = model_read(ra2, 1'b0, eff, wa, wd);
    e.c1   = c1_hold;
    e.c2   = c2_hold;
    e.busy = busy;
    e.done = busy && (sweep == DEPTH - 1);
    e.oh   = (eff && wa != 0) ? (32'h1 << wa) : 32'h0;
    q.push_back(e);
    c1_hold = e.a1;
    c2_hold = e.a2;
    if (eff && wa != 0) mem[wa] = wd;
    if (busy) begin
      mem[sweep] = 32'h0;
      sweep      = (sweep == DEPTH - 1) ? 0 : sweep + 1;
    end else if (req) begin
      sweep = 1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_rd1"}, ifa.Read_Data_1_o, 0);
    check({tag, "_a_rd2"}, ifa.Read_Data_2_o, 0);
    check({tag, "_c_rd1"}, ifc.Read_Data_1_o, 0);
    check({tag, "_c_rd2"}, ifc.Read_Data_2_o, 0);
    check({tag, "_busy"},  ifa.Busy_o, 0);
    check({tag, "_done"},  ifa.Clear_Done_o, 0);
    check({tag, "_c_busy"}, ifc.Busy_o, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      check("a_rd1", ifa.Read_Data_1_o, mon_e.a1);
      check("a_rd2", ifa.Read_Data_2_o, mon_e.a2);
      check("b_rd1", ifb.Read_Data_1_o, mon_e.b1);
      check("b_rd2", ifb.Read_Data_2_o, mon_e.b2);
      check("c_rd1", ifc.Read_Data_1_o, mon_e.c1);
      check("c_rd2", ifc.Read_Data_2_o, mon_e.c2);
      check("busy",  ifa.Busy_o,        mon_e.busy);
      check("done",  ifa.Clear_Done_o,  mon_e.done);
      check("onehot", ifa.Wr_Onehot_o,  mon_e.oh);
      check("c_done", ifc.Clear_Done_o, mon_e.done);
    end
  end

  initial begin
    reset = 1'b0;
    drive(1'b0, 0, 32'h0, 0, 0, 1'b0);
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 0, 32'h0, i, DEPTH - 1 - i, 1'b0);

    cycle(1'b1, 5, 32'hDEADBEEF, 5, 0, 1'b0);
    cycle(1'b0, 0, 32'h0, 5, 0, 1'b0);
    cycle(1'b1, 0, 32'h1234, 0, 5, 1'b0);
    cycle(1'b0, 0, 32'h0, 0, 0, 1'b0);
    cycle(1'b1, 7, 32'hA5A5A5A5, 7, 7, 1'b0);
    cycle(1'b0, 0, 32'h0, 7, 5, 1'b0);
    cycle(1'b1, 2, 32'hCAFE, 1, 1, 1'b0);
    cycle(1'b0, 0, 32'h0, 2, 2, 1'b0);
    cycle(1'b0, 0, 32'h0, 3, 2, 1'b0);

    for (int i = 1; i < DEPTH; i++) cycle(1'b1, i, 32'(i), i, i - 1, 1'b0);
    cycle(1'b1, 9, 32'h77, 9, 3, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i == 12) cycle(1'b1, 3, 32'h55, 3, 9, 1'b1);
      else         cycle(1'b0, 0, 32'h0, (i + 2) % DEPTH, (i * 7) % DEPTH, i == 20);
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 0, 32'h0, i, (i + 16) % DEPTH, 1'b0);

    for (int i = 1; i < DEPTH; i++) cycle(1'b1, i, $urandom, i, 0, 1'b0);
    cycle(1'b0, 0, 32'h0, 20, 11, 1'b1);
    for (int i = 1; i <= 10; i++) cycle(1'b0, 0, 32'h0, 20, 11, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("mid_sweep_reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 20, 32'h99, 20, 30, 1'b0);
    cycle(1'b0, 0, 32'h0, 20, 30, 1'b0);
    cycle(1'b0, 0, 32'h0, 11, 20, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      int          wa, ra1, ra2;
      bit          we, req;
      logic [31:0] wd;
      we  = $urandom_range(0, 1) == 1;
      wa  = $urandom_range(0, DEPTH - 1);
      wd  = $urandom;
      ra1 = ($urandom_range(0, 1) == 1) ? wa : $urandom_range(0, DEPTH - 1);
      ra2 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH - 1);
      req = $urandom_range(0, 79) == 0;
      cycle(we, wa, wd, ra1, ra2, req);
    end

    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the multicycle MIPS datapath, replacing the fixed 32×32 file. It adds a hardwired-zero register 0, optional write-to-read bypass, an optional registered read stage standing in for the A/B latches, and a sequential bulk-clear engine with busy/done handshake. Sits between the instruction decode stage (read addresses), the write-back mux (write data) and the ALU operand muxes.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address bits; DEPTH = 2**ADDR_W registers
- BYPASS, 1, 1 = a same-cycle write is forwarded to the matching read port
- REG_OUT, 0, 1 = read data registered (1-cycle latency); 0 = combinational read

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- Reg_Write_i  in  1  write enable
- Write_Register_i  in  ADDR_W  write address
- Write_Data_i  in  DATA_W  write data
- Read_Register_1_i  in  ADDR_W  read address, port 1
- Read_Register_2_i  in  ADDR_W  read address, port 2
- Clear_Req_i  in  1  bulk-clear request; sampled in IDLE only
- Read_Data_1_o  out  DATA_W  read data, port 1
- Read_Data_2_o  out  DATA_W  read data, port 2
- Busy_o  out  1  high while a clear sweep is running
- Clear_Done_o  out  1  one-cycle pulse on the final clear cycle
- Wr_Onehot_o  out  DEPTH  effective write-enable vector (debug)

## Operation
- Storage: DEPTH-1 registers (1..DEPTH-1); address 0 is not stored and always reads 0.
- Write: on a rising edge with Reg_Write_i=1, Busy_o=0 and Write_Register_i≠0, the addressed register loads Write_Data_i. Writes to address 0 are discarded.
- Wr_Onehot_o = one-hot(Write_Register_i) gated by Reg_Write_i & ~Busy_o; bit 0 is forced to 0.
- Read (REG_OUT=0): Read_Data_n_o = contents[Read_Register_n_i], combinational.
- Bypass (BYPASS=1): when the effective write enable is set and Write_Register_i equals a nonzero read address, that port returns Write_Data_i instead of stored contents. With BYPASS=0, the old value is returned until the edge.
- Registered read (REG_OUT=1): the combinational value above, including bypass, is captured each edge; outputs reflect the addresses from the previous cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when Clear_Req_i=1. Pointer loads 1.
  - CLEAR: the register at the pointer is zeroed each cycle, and the pointer increments.
  - When pointer = DEPTH-1, Clear_Done_o=1 and the FSM returns to IDLE next cycle.
  - Busy_o=1 exactly in CLEAR.
  - Clear_Req_i in CLEAR is ignored (no restart, no queuing).
- During CLEAR: all writes are ignored, and bypass is disabled. Reads return current stored contents, so the file can be partially cleared.
- Simultaneous Reg_Write_i and Clear_Req_i in IDLE: the write commits that edge, and the sweep starts next cycle, clearing it later.

## Timing
- Reset (reset=0, asynchronous) produces these values:
  - All registers 0, FSM IDLE, pointer 0.
  - Busy_o=0, Clear_Done_o=0.
  - Registered read outputs 0. Combinational outputs read as 0.
- Reset asserted mid-sweep aborts it immediately. No Clear_Done_o pulse is produced.
- Write-to-read: the written value is visible at the combinational read in the cycle after the edge; with BYPASS=1 it is visible in the same cycle. With REG_OUT=1, add one cycle to each.
- Clear sweep length is DEPTH-1 cycles from the first CLEAR cycle (31 for ADDR_W=5). Clear_Req_i is accepted at edge t; Busy_o is high on t+1..t+DEPTH-1; Clear_Done_o is high at t+DEPTH-1. A write is accepted again on the edge ending cycle t+DEPTH-1+1.
- Pointer width is ADDR_W; no wrap occurs, because the terminal compare stops at DEPTH-1.

## Structure
- Shared package regfile_pkg holds:
  - the state enum {IDLE, CLEAR}
  - the DEPTH derivation helper
  - the reset value constant (all zeros)
- One sub-module, wr_decoder, is the parametrised ADDR_W -> DEPTH one-hot decoder with enable input and bit-0 masking.
- Storage is a generate loop of enabled DATA_W registers, with the clear path muxing 0 into the pointer-selected entry.

## Test plan
- Reset then read all addresses -> every Read_Data_n_o = 0; Busy_o=0.
- Write 0xDEADBEEF to r5, then read r5 on port 1 and r0 on port 2 next cycle -> 0xDEADBEEF and 0. A write of 0x1234 to r0 -> r0 still reads 0.
- BYPASS=1, REG_OUT=0: in the same cycle, write 0xA5A5A5A5 to r7 and read r7 -> 0xA5A5A5A5 in that cycle. With BYPASS=0 -> the old value (0).
- Fill r1..r31 with their index, then pulse Clear_Req_i -> Busy_o high 31 cycles and Clear_Done_o one pulse on the 31st. A write of 0x55 to r3 mid-sweep is ignored, and all registers read 0 after.
- Start a sweep and assert reset at pointer 10 -> all outputs 0 asynchronously, no Clear_Done_o, FSM IDLE. A write of 0x99 to r20 after release reads back 0x99.
- REG_OUT=1: write 0xCAFE to r2, then present address 2 -> 0xCAFE appears one cycle after the address, not before.
